// File: rtl/sao_lcu_streamer.sv
// Frame sequencer for the SAO core: reads pixels in LCU-raster order (raster inside
// each LCU) plus per-LCU SAO parameters, and streams them out under busy back-pressure.
module sao_lcu_streamer #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int LCU_W  = 3,
    parameter int PAR_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lcu_size_cfg,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic [PAR_AW-1:0] par_addr,
    input  logic [23:0]       par_rdata,
    input  logic              busy,
    output logic              in_en,
    output logic [PIX_W-1:0]  din,
    output logic [1:0]        sao_type,
    output logic [4:0]        sao_band_pos,
    output logic              sao_eo_class,
    output logic [15:0]       sao_offset,
    output logic [LCU_W-1:0]  lcu_x,
    output logic [LCU_W-1:0]  lcu_y,
    output logic [1:0]        lcu_size,
    output logic              active,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic [5:0]         px_q, px_d, py_q, py_d;
    logic [LCU_W-1:0]   lx_q, lx_d, ly_q, ly_d;
    logic               in_en_q, in_en_d;
    logic [PIX_W-1:0]   din_q, din_d;
    logic [1:0]         type_q, type_d;
    logic [4:0]         band_q, band_d;
    logic               eo_q, eo_d;
    logic [15:0]        off_q, off_d;
    logic [LCU_W-1:0]   lcu_x_q, lcu_x_d, lcu_y_q, lcu_y_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic [5:0]         px_max;
    logic [LCU_W-1:0]   lx_max, ly_max;
    logic               adv, last_pix;
    logic [31:0]        side_d, row_d, col_d;

    assign px_max   = 6'((32'd16 << size_q) - 32'd1);
    assign lx_max   = LCU_W'((32'(IMG_W) >> (32'd4 + 32'(size_q))) - 32'd1);
    assign ly_max   = LCU_W'((32'(IMG_H) >> (32'd4 + 32'(size_q))) - 32'd1);
    assign adv      = !in_en_q || !busy;
    assign last_pix = (px_q == px_max) && (py_q == px_max) && (lx_q == lx_max) && (ly_q == ly_max);

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        px_d     = px_q;
        py_d     = py_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        in_en_d  = in_en_q;
        din_d    = din_q;
        type_d   = type_q;
        band_d   = band_q;
        eo_d     = eo_q;
        off_d    = off_q;
        lcu_x_d  = lcu_x_q;
        lcu_y_d  = lcu_y_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                px_d = '0;
                py_d = '0;
                lx_d = '0;
                ly_d = '0;
                if (start) begin
                    size_d   = (lcu_size_cfg == 2'd3) ? 2'd0 : lcu_size_cfg;
                    active_d = 1'b1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: state_d = S_STREAM;
            S_STREAM: begin
                if (adv) begin
                    // Counters hold the address whose data is on pix_rdata now.
                    in_en_d = 1'b1;
                    din_d   = pix_rdata;
                    if (px_q == '0 && py_q == '0) begin
                        type_d  = par_rdata[23:22];
                        band_d  = par_rdata[21:17];
                        eo_d    = par_rdata[16];
                        off_d   = par_rdata[15:0];
                        lcu_x_d = lx_q;
                        lcu_y_d = ly_q;
                    end
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end else if (px_q != px_max) begin
                        px_d = px_q + 6'd1;
                    end else begin
                        px_d = '0;
                        if (py_q != px_max) begin
                            py_d = py_q + 6'd1;
                        end else begin
                            py_d = '0;
                            if (lx_q != lx_max) begin
                                lx_d = lx_q + LCU_W'(1);
                            end else begin
                                lx_d = '0;
                                ly_d = ly_q + LCU_W'(1);
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!busy) begin
                    in_en_d = 1'b0;
                    px_d    = '0;
                    py_d    = '0;
                    lx_d    = '0;
                    ly_d    = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM addresses come from the next count so a 1-cycle read lands on the capture edge.
    assign side_d   = 32'd16 << size_d;
    assign row_d    = 32'(ly_d) * side_d + 32'(py_d);
    assign col_d    = 32'(lx_d) * side_d + 32'(px_d);
    assign pix_addr = ADDR_W'(row_d * 32'(IMG_W) + col_d);
    assign par_addr = PAR_AW'(32'(ly_d) * (32'(IMG_W) >> (32'd4 + 32'(size_d))) + 32'(lx_d));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            size_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            in_en_q  <= 1'b0;
            din_q    <= '0;
            type_q   <= '0;
            band_q   <= '0;
            eo_q     <= 1'b0;
            off_q    <= '0;
            lcu_x_q  <= '0;
            lcu_y_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            px_q     <= px_d;
            py_q     <= py_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            in_en_q  <= in_en_d;
            din_q    <= din_d;
            type_q   <= type_d;
            band_q   <= band_d;
            eo_q     <= eo_d;
            off_q    <= off_d;
            lcu_x_q  <= lcu_x_d;
            lcu_y_q  <= lcu_y_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign in_en        = in_en_q;
    assign din          = din_q;
    assign sao_type     = type_q;
    assign sao_band_pos = band_q;
    assign sao_eo_class = eo_q;
    assign sao_offset   = off_q;
    assign lcu_x        = lcu_x_q;
    assign lcu_y        = lcu_y_q;
    assign lcu_size     = size_q;
    assign active       = active_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sao_lcu_streamer.sv
// Directed bench for sao_lcu_streamer: a 32x32 instance for scan/latency/stall/reset
// scenarios and a default 128x128 instance for a randomly stalled 64x64 LCU scan.
module tb_sao_lcu_streamer;
    localparam int SW = 32, SH = 32, S_AW = 10, S_LW = 1, S_PW = 2;
    localparam int BW = 128, BH = 128, B_AW = 14, B_LW = 3, B_PW = 6, B_PIX = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    logic            s_start = 1'b0, s_busy = 1'b0;
    logic [1:0]      s_cfg = 2'd0;
    logic [S_AW-1:0] s_pix_addr;
    logic [7:0]      s_pix_rdata = '0, s_din;
    logic [S_PW-1:0] s_par_addr;
    logic [23:0]     s_par_rdata = '0;
    logic            s_in_en, s_eo, s_active, s_done;
    logic [1:0]      s_type, s_size;
    logic [4:0]      s_band;
    logic [15:0]     s_off;
    logic [S_LW-1:0] s_lx, s_ly;

    logic             b_start = 1'b0, b_busy = 1'b0;
    logic [1:0]       b_cfg = 2'd0;
    logic [B_AW-1:0]  b_pix_addr;
    logic [B_PIX-1:0] b_pix_rdata = '0, b_din;
    logic [B_PW-1:0]  b_par_addr;
    logic [23:0]      b_par_rdata = '0;
    logic             b_in_en, b_eo, b_active, b_done;
    logic [1:0]       b_type, b_size;
    logic [4:0]       b_band;
    logic [15:0]      b_off;
    logic [B_LW-1:0]  b_lx, b_ly;

    sao_lcu_streamer #(.PIX_W(8), .IMG_W(SW), .IMG_H(SH), .ADDR_W(S_AW), .LCU_W(S_LW), .PAR_AW(S_PW)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .lcu_size_cfg(s_cfg),
        .pix_addr(s_pix_addr), .pix_rdata(s_pix_rdata), .par_addr(s_par_addr), .par_rdata(s_par_rdata),
        .busy(s_busy), .in_en(s_in_en), .din(s_din), .sao_type(s_type), .sao_band_pos(s_band),
        .sao_eo_class(s_eo), .sao_offset(s_off), .lcu_x(s_lx), .lcu_y(s_ly), .lcu_size(s_size),
        .active(s_active), .done(s_done));

    sao_lcu_streamer #(.PIX_W(B_PIX), .IMG_W(BW), .IMG_H(BH), .ADDR_W(B_AW), .LCU_W(B_LW), .PAR_AW(B_PW)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .lcu_size_cfg(b_cfg),
        .pix_addr(b_pix_addr), .pix_rdata(b_pix_rdata), .par_addr(b_par_addr), .par_rdata(b_par_rdata),
        .busy(b_busy), .in_en(b_in_en), .din(b_din), .sao_type(b_type), .sao_band_pos(b_band),
        .sao_eo_class(b_eo), .sao_offset(b_off), .lcu_x(b_lx), .lcu_y(b_ly), .lcu_size(b_size),
        .active(b_active), .done(b_done));

    function automatic logic [23:0] par_word(input int n);
        logic [31:0] v;
        v = n;
        return {v[1:0], v[4:0], v[0], v[15:0]};
    endfunction

    // Synchronous SRAM models: pix[a] = a, par[n] = par_word(n).
    always @(posedge clk) begin
        s_pix_rdata <= s_pix_addr[7:0];
        s_par_rdata <= par_word(int'(s_par_addr));
        b_pix_rdata <= b_pix_addr;
        b_par_rdata <= par_word(int'(b_par_addr));
    end

    int n_checks = 0;
    int n_fail   = 0;
    int v256_din, v256_lx, v256_ly, v256_off;

    task automatic model_pix(input int k, input int s, input int w, output int addr, output int lx, output int ly);
        int per, lcu, r;
        per  = s * s;
        lcu  = k / per;
        r    = k % per;
        lx   = lcu % (w / s);
        ly   = lcu / (w / s);
        addr = (ly * s + r / s) * w + lx * s + r % s;
    endtask

    // Runs one frame on the 32x32 instance and reports stream statistics.
    task automatic run_small(input logic [1:0] cfg, input int mid_start_k, input int reset_k,
                             output int n_xfer, output int n_bad, output int done_cyc,
                             output int first_en, output int n_side_bad);
        int s, a, lx, ly, n;
        logic [1:0] exp_size;
        exp_size = (cfg == 2'd3) ? 2'd0 : cfg;
        s = 16 << exp_size;
        n_xfer = 0; n_bad = 0; done_cyc = -1; first_en = -1; n_side_bad = 0;
        @(negedge clk);
        s_cfg = cfg; s_start = 1'b1; s_busy = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (s_done) begin
                done_cyc = cyc;
                break;
            end
            s_start = 1'b0;
            if (s_in_en && first_en < 0) first_en = cyc;
            if (s_size !== exp_size) n_side_bad++;
            if (cfg == 2'd1 && s_par_addr !== '0) n_side_bad++;
            if (s_in_en && !s_busy) begin
                model_pix(n_xfer, s, SW, a, lx, ly);
                n = ly * (SW / s) + lx;
                if (s_din !== 8'(a) || s_lx !== S_LW'(lx) || s_ly !== S_LW'(ly) ||
                    s_off !== 16'(n) || s_type !== 2'(n)) n_bad++;
                if (n_xfer == 256) begin
                    v256_din = int'(s_din); v256_lx = int'(s_lx); v256_ly = int'(s_ly); v256_off = int'(s_off);
                end
                if (n_xfer == mid_start_k) begin
                    s_start = 1'b1;
                    s_cfg   = 2'd1;
                end
                if (n_xfer == reset_k) begin
                    reset = 1'b1;
                    n_xfer++;
                    break;
                end
                n_xfer++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (s_in_en !== 1'b0) begin n_fail++; $display("FAIL reset_in_en: got %0b expected 0", s_in_en); end
        n_checks++; if (s_done !== 1'b0 || s_active !== 1'b0) begin n_fail++; $display("FAIL reset_done_active: got %0b%0b expected 00", s_done, s_active); end
        n_checks++; if (s_pix_addr !== '0 || s_par_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", s_pix_addr, s_par_addr); end
        n_checks++; if (s_din !== '0 || s_off !== '0 || s_size !== '0) begin n_fail++; $display("FAIL reset_data: got din %0d off %0d size %0d expected 0", s_din, s_off, s_size); end
        n_checks++; if (b_active !== 1'b0 || b_in_en !== 1'b0) begin n_fail++; $display("FAIL reset_big: got %0b%0b expected 00", b_active, b_in_en); end
        reset = 1'b0;
    endtask

    task automatic test_lcu16;
        int nx, nb, dc, fe, sb;
        run_small(2'd0, -1, -1, nx, nb, dc, fe, sb);
        n_checks++; if (nx != 1024) begin n_fail++; $display("FAIL lcu16_count: got %0d expected 1024", nx); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL lcu16_stream: got %0d bad transfers expected 0", nb); end
        n_checks++; if (fe != 2) begin n_fail++; $display("FAIL lcu16_first_en: got %0d expected 2", fe); end
        n_checks++; if (dc != 1027) begin n_fail++; $display("FAIL lcu16_done_cycle: got %0d expected 1027", dc); end
        n_checks++; if (v256_din != 16 || v256_lx != 1 || v256_ly != 0 || v256_off != 1) begin
            n_fail++; $display("FAIL lcu16_xfer256: got din %0d x %0d y %0d off %0d expected 16 1 0 1", v256_din, v256_lx, v256_ly, v256_off);
        end
        n_checks++; if (s_active !== 1'b0) begin n_fail++; $display("FAIL lcu16_active_at_done: got %0b expected 0", s_active); end
        n_checks++; if (sb != 0) begin n_fail++; $display("FAIL lcu16_size: got %0d bad cycles expected 0", sb); end
    endtask

    task automatic test_lcu32;
        int nx, nb, dc, fe, sb;
        run_small(2'd1, -1, -1, nx, nb, dc, fe, sb);
        n_checks++; if (nx != 1024) begin n_fail++; $display("FAIL lcu32_count: got %0d expected 1024", nx); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL lcu32_raster: got %0d bad transfers expected 0", nb); end
        n_checks++; if (sb != 0) begin n_fail++; $display("FAIL lcu32_par_addr_size: got %0d bad cycles expected 0", sb); end
        n_checks++; if (dc != 1027) begin n_fail++; $display("FAIL lcu32_done_cycle: got %0d expected 1027", dc); end
    endtask

    task automatic test_busy_first;
        int first_en, unstable;
        logic [S_AW-1:0] a0;
        first_en = -1; unstable = 0;
        @(negedge clk);
        s_cfg = 2'd0; s_start = 1'b1; s_busy = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (s_in_en) begin
                first_en = cyc;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (first_en != 2) begin n_fail++; $display("FAIL busy_first_en: got %0d expected 2", first_en); end
        s_busy = 1'b1;
        #1;
        a0 = s_pix_addr;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (s_in_en !== 1'b1 || s_din !== 8'd0 || s_pix_addr !== a0) unstable++;
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL busy_hold: got %0d unstable cycles expected 0", unstable); end
        @(negedge clk);
        n_checks++; if (s_din !== 8'd0 || s_in_en !== 1'b1) begin n_fail++; $display("FAIL busy_release_pix0: got din %0d en %0b expected 0 1", s_din, s_in_en); end
        s_busy = 1'b0;
        @(negedge clk);
        n_checks++; if (s_din !== 8'd1 || s_in_en !== 1'b1) begin n_fail++; $display("FAIL busy_release_pix1: got din %0d en %0b expected 1 1", s_din, s_in_en); end
        @(negedge clk);
        n_checks++; if (s_din !== 8'd2) begin n_fail++; $display("FAIL busy_release_pix2: got din %0d expected 2", s_din); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nx, nb, dc, fe, sb, pulses;
        run_small(2'd0, -1, 500, nx, nb, dc, fe, sb);
        n_checks++; if (nb != 0 || nx != 501) begin n_fail++; $display("FAIL rmid_prefix: got %0d xfers %0d bad expected 501 0", nx, nb); end
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (s_in_en !== 1'b0 || s_active !== 1'b0 || s_done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ctrl: got en %0b act %0b done %0b expected 0 0 0", s_in_en, s_active, s_done);
        end
        n_checks++; if (s_din !== '0 || s_off !== '0 || s_type !== '0 || s_lx !== '0 || s_ly !== '0 || s_size !== '0) begin
            n_fail++; $display("FAIL rmid_data: got din %0d off %0d lx %0d ly %0d expected 0", s_din, s_off, s_lx, s_ly);
        end
        n_checks++; if (s_pix_addr !== '0 || s_par_addr !== '0) begin n_fail++; $display("FAIL rmid_addr: got %0d/%0d expected 0/0", s_pix_addr, s_par_addr); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_done !== 1'b0 || s_active !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d bad cycles expected 0", pulses); end
        run_small(2'd0, -1, -1, nx, nb, dc, fe, sb);
        n_checks++; if (nx != 1024 || nb != 0 || dc != 1027) begin
            n_fail++; $display("FAIL rmid_replay: got %0d xfers %0d bad done %0d expected 1024 0 1027", nx, nb, dc);
        end
    endtask

    task automatic test_start_ignored_cfg3;
        int nx, nb, dc, fe, sb;
        run_small(2'd3, 100, -1, nx, nb, dc, fe, sb);
        n_checks++; if (nx != 1024 || nb != 0) begin n_fail++; $display("FAIL cfg3_stream: got %0d xfers %0d bad expected 1024 0", nx, nb); end
        n_checks++; if (sb != 0) begin n_fail++; $display("FAIL cfg3_lcu_size: got %0d bad cycles expected 0", sb); end
        n_checks++; if (dc != 1027) begin n_fail++; $display("FAIL cfg3_done_cycle: got %0d expected 1027", dc); end
    endtask

    task automatic test_big_random;
        int nx, nb, done_cyc, a, lx, ly, n;
        nx = 0; nb = 0; done_cyc = -1;
        @(negedge clk);
        b_cfg = 2'd2; b_start = 1'b1; b_busy = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            if (b_done) begin
                done_cyc = cyc;
                break;
            end
            b_busy = 1'($urandom_range(1));
            if (b_in_en && !b_busy) begin
                model_pix(nx, 64, BW, a, lx, ly);
                n = ly * (BW / 64) + lx;
                if (b_din !== B_PIX'(a) || b_lx !== B_LW'(lx) || b_ly !== B_LW'(ly) ||
                    b_off !== 16'(n) || b_band !== 5'(n)) nb++;
                nx++;
            end
            @(negedge clk);
        end
        b_busy = 1'b0;
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL big_done_timeout: got no done expected done within budget"); end
        n_checks++; if (nx != 16384) begin n_fail++; $display("FAIL big_count: got %0d expected 16384", nx); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL big_stream: got %0d bad transfers expected 0", nb); end
        n_checks++; if (b_size !== 2'd2) begin n_fail++; $display("FAIL big_lcu_size: got %0d expected 2", b_size); end
    endtask

    initial begin
        test_reset();
        test_lcu16();
        test_lcu32();
        test_busy_first();
        test_reset_mid();
        test_start_ignored_cfg3();
        test_big_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
